// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Holds the controller state encoding and the default NOP encoding.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_RUN,
    ST_LOAD
  } state_t;

  localparam logic [7:0] NOP_WORD_DEFAULT = 8'h00;

endpackage

// File: rtl/imem_ram.sv
// Single-write-port, single synchronous-read-port word store.
// The read register only updates when re is high, so callers can hold the last fetched word.
module imem_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; the clear sweep initialises it instead.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_loadable.sv
// Instruction memory with registered fetch port, run-time streaming load port
// and a NOP clear sweep after every reset.
module instr_mem_loadable
  import imem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              instr_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              busy,
  output logic              load_done
);

  localparam int                RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [RAM_AW-1:0] LAST    = RAM_AW'(DEPTH - 1);
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W + 1)'(1);

  state_t              state, state_nx;
  logic [RAM_AW-1:0]   clr_addr, wr_addr;
  logic [ADDR_W:0]     remaining;
  logic [ADDR_W:0]     base_rem;
  logic                instr_nop;
  logic [DATA_W-1:0]   ram_q;
  logic                pc_in_range, fetch_go;
  logic                ram_we, ram_re;
  logic [RAM_AW-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;

  assign pc_in_range = {1'b0, pc} < DEPTH_X;
  assign fetch_go    = (state == ST_RUN) && fetch_en && !stall;
  assign ram_re      = fetch_go && pc_in_range;
  assign base_rem    = {1'b0, load_base} % DEPTH_X;

  assign busy        = (state != ST_RUN);
  assign load_ready  = (state == ST_LOAD);
  // Out-of-range fetches and non-RUN cycles present NOP without touching the RAM read register.
  assign instr       = instr_nop ? NOP_WORD : ram_q;

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nx  = state;
    ram_we    = 1'b0;
    ram_waddr = clr_addr;
    ram_wdata = NOP_WORD;
    unique case (state)
      ST_CLEAR: begin
        ram_we = 1'b1;
        if (clr_addr == LAST) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (load_start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        if (load_valid) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = load_data;
          if (remaining == REM_ONE) state_nx = ST_RUN;
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
    // Reset aborts immediately: no write lands on the reset edge.
    if (reset) ram_we = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_CLEAR;
      clr_addr    <= '0;
      wr_addr     <= '0;
      remaining   <= '0;
      load_done   <= 1'b0;
      instr_nop   <= 1'b1;
      instr_valid <= 1'b0;
      instr_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      load_done <= 1'b0;

      unique case (state)
        ST_CLEAR: clr_addr <= (clr_addr == LAST) ? '0 : clr_addr + 1'b1;
        ST_RUN: begin
          if (load_start) begin
            wr_addr   <= RAM_AW'(base_rem);
            remaining <= (load_len == '0) ? REM_ONE : load_len;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            wr_addr   <= (wr_addr == LAST) ? '0 : wr_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == REM_ONE) load_done <= 1'b1;
          end
        end
        default: ;
      endcase

      if (!stall) begin
        if (state == ST_RUN) begin
          if (fetch_en) begin
            instr_nop   <= !pc_in_range;
            instr_err   <= !pc_in_range;
            instr_valid <= 1'b1;
          end else begin
            instr_valid <= 1'b0;
          end
        end else begin
          instr_nop   <= 1'b1;
          instr_err   <= 1'b0;
          instr_valid <= 1'b0;
        end
      end
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (RAM_AW'(pc)),
    .rdata (ram_q)
  );

endmodule
